// File: rtl/serial_io_master.sv
// serial_io_master: SPI-style master for the FPGA serial register bus (clk64 domain).
// Issues 40-bit frames {rw, addr[6:0], data[31:0]} MSB first on sclk/sen_n/sdi.
// Readback of sdo into rdata is included only when SERIAL_IO_MASTER_READBACK_EN
// is defined; otherwise every frame is a write and rdata reads as zero.
//
// state | meaning
// IDLE  | waiting for start, sen_n high, not busy
// SETUP | sen_n low, first bit on sdi, sclk low
// HIGH  | sclk high, slave samples sdi, master samples sdo
// LOW   | sclk low, next bit presented on sdi
// HOLD  | sclk low after the last rising edge, sen_n still low
// GAP   | sen_n high for the minimum deassert time, still busy
module serial_io_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        rw,
    input  logic [6:0]  addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        sclk,
    output logic        sen_n,
    output logic        sdi,
    input  logic        sdo
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_HOLD,
        S_GAP
    } state_t;

    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

    state_t      state;
    state_t      next_state;
    logic [7:0]  div_cnt;
    logic [5:0]  bit_cnt;
    logic [38:0] shift_reg;
    logic [39:0] frame_in;
    logic        accept;
    logic        tc;
    logic        busy_d;
    logic        done_d;
    logic        sclk_d;
    logic        sen_n_d;

    assign accept = start && (state == S_IDLE);
    assign tc     = (div_cnt == 8'd0);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: every non-idle state lasts one full divider period.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_SETUP;
            S_SETUP: if (tc) next_state = S_HIGH;
            S_HIGH:  if (tc) next_state = (bit_cnt == 6'd39) ? S_HOLD : S_LOW;
            S_LOW:   if (tc) next_state = S_HIGH;
            S_HOLD:  if (tc) next_state = S_GAP;
            S_GAP:   if (tc) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the bus pins can be registered.
    always_comb begin
        busy_d  = (next_state != S_IDLE);
        done_d  = (state == S_GAP) && (next_state == S_IDLE);
        sclk_d  = (next_state == S_HIGH);
        sen_n_d = !((next_state == S_SETUP) || (next_state == S_HIGH) ||
                    (next_state == S_LOW)   || (next_state == S_HOLD));
    end

    // Registered control outputs, glitch-free on the serial pins.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            sclk  <= 1'b0;
            sen_n <= 1'b1;
        end else begin
            busy  <= busy_d;
            done  <= done_d;
            sclk  <= sclk_d;
            sen_n <= sen_n_d;
        end
    end

    // Divider, bit counter and shifter; sdi acts as the top bit of the shifter.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt   <= DIV_LOAD;
            bit_cnt   <= '0;
            shift_reg <= '0;
            sdi       <= 1'b0;
        end else begin
            if ((state == S_IDLE) || (next_state != state)) begin
                div_cnt <= DIV_LOAD;
            end else begin
                div_cnt <= div_cnt - 8'd1;
            end

            if (accept) begin
                bit_cnt   <= '0;
                shift_reg <= frame_in[38:0];
                sdi       <= frame_in[39];
            end else if ((state == S_HIGH) && tc) begin
                bit_cnt <= bit_cnt + 6'd1;
                if (next_state == S_LOW) begin
                    shift_reg <= {shift_reg[37:0], 1'b0};
                    sdi       <= shift_reg[38];
                end
            end else if (next_state == S_GAP) begin
                sdi <= 1'b0;
            end
        end
    end

`ifdef SERIAL_IO_MASTER_READBACK_EN
    logic        rd_frame;
    logic [31:0] rd_shift;

    assign frame_in = rw ? {1'b1, addr, 32'h0000_0000} : {1'b0, addr, wdata};

    // Sample sdo in the first cycle of each data-bit high phase; publish at done.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_frame <= 1'b0;
            rd_shift <= '0;
            rdata    <= '0;
        end else begin
            if (accept) begin
                rd_frame <= rw;
            end
            if ((state == S_HIGH) && (div_cnt == DIV_LOAD) && (bit_cnt >= 6'd8)) begin
                rd_shift <= {rd_shift[30:0], sdo};
            end
            if (done_d && rd_frame) begin
                rdata <= rd_shift;
            end
        end
    end
`else
    logic unused_inputs;

    assign frame_in      = {1'b0, addr, wdata};
    assign rdata         = 32'h0000_0000;
    assign unused_inputs = rw ^ sdo;
`endif

endmodule

// File: tb/tb_serial_io_master.sv
// tb_serial_io_master: directed bench for serial_io_master with a serial slave model.
// One instance at CLK_DIV=4 covers write, readback/ignored-rw, busy-start and reset
// cases; a second instance at CLK_DIV=1 covers back-to-back frames.
module tb_serial_io_master;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        rw;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        sclk;
    logic        sen_n;
    logic        sdi;
    logic        sdo;

    logic        start1;
    logic        busy1;
    logic        done1;
    logic [31:0] rdata1;
    logic        sclk1;
    logic        sen_n1;
    logic        sdi1;

    int n_assert = 0;
    int n_fail   = 0;

    int busy_total = 0;
    int done_total = 0;
    int rises      = 0;
    int falls      = 0;
    int fall_base  = 0;
    int rises1     = 0;
    int fk;

    logic [39:0] cap     = '0;
    logic [31:0] rd_word = 32'h0;

    always #5 clock = ~clock;

    serial_io_master #(.CLK_DIV(4)) u_dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .rw    (rw),
        .addr  (addr),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .rdata (rdata),
        .sclk  (sclk),
        .sen_n (sen_n),
        .sdi   (sdi),
        .sdo   (sdo)
    );

    serial_io_master #(.CLK_DIV(1)) u_dut1 (
        .clock (clock),
        .reset (reset),
        .start (start1),
        .rw    (1'b0),
        .addr  (7'h2A),
        .wdata (32'h0000_0000),
        .busy  (busy1),
        .done  (done1),
        .rdata (rdata1),
        .sclk  (sclk1),
        .sen_n (sen_n1),
        .sdi   (sdi1),
        .sdo   (1'b0)
    );

    // Cycle counters sampled mid-cycle.
    always @(negedge clock) begin
        if (busy === 1'b1) busy_total++;
        if (done === 1'b1) done_total++;
    end

    // Slave model: capture sdi on rising sclk, drive sdo for the phase after each fall.
    always @(posedge sclk) begin
        cap   <= {cap[38:0], sdi};
        rises <= rises + 1;
    end
    always @(negedge sclk) falls = falls + 1;
    always @(negedge sen_n) fall_base = falls;
    always @(posedge sclk1) rises1 <= rises1 + 1;

    assign fk  = falls - fall_base;
    assign sdo = (fk >= 8 && fk < 40) ? rd_word[5'(39 - fk)] : 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_frame(input logic rw_v, input logic [6:0] a_v, input logic [31:0] d_v);
        rw    = rw_v;
        addr  = a_v;
        wdata = d_v;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            tick();
            if (done === 1'b1) ok = 1'b1;
        end
    endtask

    initial begin
        int b0;
        int d0;
        int r0;
        int r10;
        int c;
        int g;
        bit ok;

        reset  = 1'b1;
        start  = 1'b0;
        rw     = 1'b0;
        addr   = 7'h00;
        wdata  = 32'h0;
        start1 = 1'b0;
        repeat (3) tick();

        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rdata", rdata, 0);
        check("rst_sclk", sclk, 0);
        check("rst_sen_n", sen_n, 1);
        check("rst_sdi", sdi, 0);
        reset = 1'b0;
        tick();

        // Plain write frame.
        b0 = busy_total; d0 = done_total; r0 = rises;
        start_frame(1'b0, 7'h05, 32'hDEADBEEF);
        check("t1_busy_next", busy, 1);
        check("t1_sen_n_low", sen_n, 0);
        wait_done(400, ok);
        check("t1_done_seen", ok, 1);
        check("t1_busy_at_done", busy, 0);
        tick();
        check("t1_done_pulse", done, 0);
        check("t1_busy_cycles", busy_total - b0, 328);
        check("t1_done_count", done_total - d0, 1);
        check("t1_rises", rises - r0, 40);
        check("t1_frame", cap, {1'b0, 7'h05, 32'hDEADBEEF});

`ifdef SERIAL_IO_MASTER_READBACK_EN
        // Readback frame: slave returns a word on sdo.
        rd_word = 32'hF0F0931A;
        r0 = rises;
        start_frame(1'b1, 7'h03, 32'h12345678);
        wait_done(400, ok);
        check("t2_done_seen", ok, 1);
        check("t2_rdata", rdata, 32'hF0F0931A);
        tick();
        check("t2_rises", rises - r0, 40);
        check("t2_frame", cap, {1'b1, 7'h03, 32'h0000_0000});
        rd_word = 32'h0;
`else
        // rw is ignored without readback support.
        r0 = rises;
        start_frame(1'b1, 7'h10, 32'h0000_0001);
        wait_done(400, ok);
        check("t6_done_seen", ok, 1);
        tick();
        check("t6_rises", rises - r0, 40);
        check("t6_frame", cap, {1'b0, 7'h10, 32'h0000_0001});
        check("t6_rdata", rdata, 0);
`endif

        // Start while busy is ignored and input changes do not disturb the frame.
        b0 = busy_total; d0 = done_total; r0 = rises;
        start_frame(1'b0, 7'h05, 32'hDEADBEEF);
        repeat (99) tick();
        start = 1'b1; addr = 7'h7F; wdata = 32'h0; rw = 1'b1;
        tick();
        start = 1'b0;
        check("t3_still_busy", busy, 1);
        wait_done(400, ok);
        check("t3_done_seen", ok, 1);
        tick();
        check("t3_busy_cycles", busy_total - b0, 328);
        check("t3_done_count", done_total - d0, 1);
        check("t3_rises", rises - r0, 40);
        check("t3_frame", cap, {1'b0, 7'h05, 32'hDEADBEEF});
`ifdef SERIAL_IO_MASTER_READBACK_EN
        check("t3_rdata_kept", rdata, 32'hF0F0931A);
`endif

        // Reset in the middle of a frame, then a clean frame.
        start_frame(1'b0, 7'h05, 32'hDEADBEEF);
        repeat (149) tick();
        reset = 1'b1;
        tick();
        check("t4_sen_n", sen_n, 1);
        check("t4_sclk", sclk, 0);
        check("t4_busy", busy, 0);
        check("t4_done", done, 0);
        check("t4_rdata", rdata, 0);
        reset = 1'b0;
        d0 = done_total;
        repeat (5) tick();
        check("t4_no_done", done_total - d0, 0);
        b0 = busy_total; d0 = done_total; r0 = rises;
        start_frame(1'b0, 7'h22, 32'h01234567);
        wait_done(400, ok);
        check("t4_done_seen", ok, 1);
        tick();
        check("t4_busy_cycles", busy_total - b0, 328);
        check("t4_done_count", done_total - d0, 1);
        check("t4_rises", rises - r0, 40);
        check("t4_frame", cap, {1'b0, 7'h22, 32'h01234567});

        // CLK_DIV=1 with start held high: back-to-back frames.
        r10 = rises1;
        start1 = 1'b1;
        c = 0;
        while (busy1 !== 1'b1 && c < 10) begin tick(); c++; end
        check("t5_busy_rise", busy1, 1);
        c = 0;
        while (busy1 === 1'b1 && c < 200) begin c++; tick(); end
        check("t5_busy_len1", c, 82);
        check("t5_done1", done1, 1);
        check("t5_sen_n_idle", sen_n1, 1);
        g = 0;
        while (busy1 !== 1'b1 && g < 10) begin g++; tick(); end
        check("t5_gap", g, 1);
        c = 0;
        while (busy1 === 1'b1 && c < 200) begin c++; tick(); end
        check("t5_busy_len2", c, 82);
        check("t5_rises", rises1 - r10, 80);
        start1 = 1'b0;
        repeat (100) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
